// File: rtl/cordic_sched_pkg.sv
// Shared types and defaults for the cosine-engine request scheduler.
package cordic_sched_pkg;

  localparam int unsigned NREQ_DEF = 4;
  localparam int unsigned W_DEF    = 22;
  localparam int unsigned TMO_DEF  = 31;
  localparam int unsigned CNT_W    = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    OUT  = 2'd3
  } state_t;

  // Requester index width; never narrower than one bit.
  function automatic int unsigned tag_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cordic_sched_rr_arbiter.sv
// Round-robin one-hot arbiter: search begins at ptr and wraps.
module rr_arbiter
  import cordic_sched_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEF,
  localparam int unsigned TW  = tag_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [TW-1:0]   ptr,
  output logic [NREQ-1:0] gnt
);

  int   idx;
  logic found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < int'(NREQ); i++) begin
      idx = int'(ptr) + i;
      if (idx >= int'(NREQ)) idx = idx - int'(NREQ);
      if (!found && req[TW'(idx)]) begin
        gnt[TW'(idx)] = 1'b1;
        found         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cordic_sched.sv
// Shares one external cosine engine between NREQ requesters with
// round-robin grant, bounded run time and a held result handshake.
module cordic_sched
  import cordic_sched_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEF,
  parameter int unsigned W    = W_DEF,
  parameter int unsigned TMO  = TMO_DEF
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*W-1:0]        req_angle,
  output logic [NREQ-1:0]          req_ready,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [W-1:0]             res_cos,
  output logic [tag_w(NREQ)-1:0]   res_tag,
  output logic                     res_err,
  output logic                     busy,
  output logic                     eng_reset,
  output logic [W-1:0]             eng_angle,
  input  logic [W-1:0]             eng_cos,
  input  logic                     eng_done
);

  localparam int unsigned TW = tag_w(NREQ);

  state_t           state;
  logic [TW-1:0]    ptr;
  logic [TW-1:0]    cur_tag;
  logic [CNT_W-1:0] cnt;
  logic [NREQ-1:0]  gnt;
  logic [TW-1:0]    gnt_idx;
  logic [TW-1:0]    ptr_next;
  logic [W-1:0]     gnt_angle;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req (req_valid),
    .ptr (ptr),
    .gnt (gnt)
  );

  // Accept is only offered from IDLE and never while reset is held.
  assign req_ready = (state == IDLE && reset_n) ? gnt : '0;

  always_comb begin
    gnt_idx   = '0;
    gnt_angle = '0;
    for (int k = 0; k < int'(NREQ); k++) begin
      if (gnt[k]) begin
        gnt_idx   = TW'(k);
        gnt_angle = req_angle[k*W +: W];
      end
    end
    ptr_next = (gnt_idx == TW'(NREQ - 1)) ? '0 : gnt_idx + TW'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      ptr       <= '0;
      cur_tag   <= '0;
      cnt       <= '0;
      res_valid <= 1'b0;
      res_cos   <= '0;
      res_tag   <= '0;
      res_err   <= 1'b0;
      busy      <= 1'b0;
      eng_reset <= 1'b0;
      eng_angle <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req_valid) begin
            state     <= LOAD;
            busy      <= 1'b1;
            eng_reset <= 1'b1;
            eng_angle <= gnt_angle;
            cur_tag   <= gnt_idx;
            ptr       <= ptr_next;
          end
        end
        LOAD: begin
          state     <= RUN;
          eng_reset <= 1'b0;
          cnt       <= '0;
        end
        RUN: begin
          // Done is tested first so it wins over a coincident timeout.
          if (eng_done) begin
            state     <= OUT;
            res_valid <= 1'b1;
            res_cos   <= eng_cos;
            res_err   <= 1'b0;
            res_tag   <= cur_tag;
            eng_angle <= '0;
          end else if (cnt == CNT_W'(TMO)) begin
            state     <= OUT;
            res_valid <= 1'b1;
            res_cos   <= '0;
            res_err   <= 1'b1;
            res_tag   <= cur_tag;
            eng_angle <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        OUT: begin
          if (res_ready) begin
            state     <= IDLE;
            res_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_sched.sv
// Directed scoreboard bench for cordic_sched with a programmable stub engine.
module tb_cordic_sched;

  localparam int unsigned NREQ = 4;
  localparam int unsigned W    = 22;

  logic              clk;
  logic              reset_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_angle;
  logic [NREQ-1:0]   req_ready;
  logic              res_valid;
  logic              res_ready;
  logic [W-1:0]      res_cos;
  logic [1:0]        res_tag;
  logic              res_err;
  logic              busy;
  logic              eng_reset;
  logic [W-1:0]      eng_angle;
  logic [W-1:0]      eng_cos;
  logic              eng_done;

  logic [W-1:0] ang [NREQ];
  int           stub_lat;
  int           stub_cnt;
  logic [W-1:0] stub_cos;

  int total;
  int bad;
  logic [W+2:0] sb [$];

  cordic_sched #(.NREQ(NREQ), .W(W), .TMO(31)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_angle (req_angle),
    .req_ready (req_ready),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_cos   (res_cos),
    .res_tag   (res_tag),
    .res_err   (res_err),
    .busy      (busy),
    .eng_reset (eng_reset),
    .eng_angle (eng_angle),
    .eng_cos   (eng_cos),
    .eng_done  (eng_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign req_angle = {ang[3], ang[2], ang[1], ang[0]};
  assign eng_cos   = stub_cos;
  assign eng_done  = (stub_lat >= 0) && (stub_cnt >= stub_lat);

  // Stub engine: counts cycles since its last restart, done is a level.
  always @(posedge clk) begin
    if (eng_reset) stub_cnt <= 0;
    else if (stub_cnt < 1000) stub_cnt <= stub_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Waits for the grant, checks LOAD/RUN entry, then the result latency and payload.
  task automatic run_op(input int tag, input logic [W-1:0] exp_angle, input logic [W-1:0] exp_cos,
                        input logic exp_err, input int exp_lat, input int drop);
    int         n;
    int         tries;
    logic       seen;
    logic [3:0] oh;
    logic [W+2:0] exp_res;
    seen  = 1'b0;
    tries = 0;
    #1;
    seen = (req_ready != 0);
    while (!seen && tries < 50) begin
      @(negedge clk);
      #1;
      seen = (req_ready != 0);
      tries++;
    end
    chk("grant_seen", 64'(seen), 64'(1));
    oh = 4'b0001 << tag;
    chk("grant_onehot", 64'(req_ready), 64'(oh));
    sb.push_back({2'(tag), exp_err, exp_cos});
    @(negedge clk);
    if (drop == 1) req_valid[2'(tag)] = 1'b0;
    else if (drop == 2) req_valid = '0;
    chk("load_eng_reset", 64'(eng_reset), 64'(1));
    chk("load_eng_angle", 64'(eng_angle), 64'(exp_angle));
    chk("load_ready_zero", 64'(req_ready), 64'(0));
    @(negedge clk);
    n = 2;
    chk("run_eng_reset", 64'(eng_reset), 64'(0));
    chk("run_busy", 64'(busy), 64'(1));
    while (!res_valid && n < 80) begin
      @(negedge clk);
      n++;
    end
    chk("res_latency", 64'(n), 64'(exp_lat));
    chk("sb_nonempty", 64'(sb.size() != 0), 64'(1));
    if (sb.size() != 0) begin
      exp_res = sb.pop_front();
      chk("result", 64'({res_tag, res_err, res_cos}), 64'(exp_res));
    end
  endtask

  initial begin
    logic [26:0] hold_exp;
    total     = 0;
    bad       = 0;
    reset_n   = 1'b0;
    req_valid = 4'hF;
    res_ready = 1'b1;
    stub_lat  = 15;
    stub_cos  = 22'h26DD3;
    ang[0] = 22'h00100;
    ang[1] = 22'h00200;
    ang[2] = 22'h01234;
    ang[3] = 22'h00400;

    // Reset state with requests already pending
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", 64'(req_ready), 64'(0));
    chk("rst_outputs", 64'({res_valid, res_cos, res_tag, res_err, busy, eng_reset, eng_angle}), 64'(0));

    // Round robin from requester 0 with all four continuously requesting
    @(negedge clk);
    reset_n = 1'b1;
    run_op(0, ang[0], 22'h26DD3, 1'b0, 18, 0);
    run_op(1, ang[1], 22'h26DD3, 1'b0, 18, 0);
    run_op(2, ang[2], 22'h26DD3, 1'b0, 18, 0);
    run_op(3, ang[3], 22'h26DD3, 1'b0, 18, 0);
    run_op(0, ang[0], 22'h26DD3, 1'b0, 18, 2);

    // Single request on requester 2 with a different engine value
    @(negedge clk);
    stub_cos     = 22'h1ABCD;
    req_valid[2] = 1'b1;
    run_op(2, 22'h01234, 22'h1ABCD, 1'b0, 18, 1);

    // Engine never finishes: timeout result, then a normal grant
    @(negedge clk);
    stub_lat     = -1;
    req_valid[1] = 1'b1;
    run_op(1, ang[1], 22'h0, 1'b1, 34, 1);
    @(negedge clk);
    stub_lat     = 15;
    stub_cos     = 22'h26DD3;
    req_valid[0] = 1'b1;
    run_op(0, ang[0], 22'h26DD3, 1'b0, 18, 1);

    // Consumer stalls in OUT while requester 1 waits
    @(negedge clk);
    res_ready    = 1'b0;
    req_valid[3] = 1'b1;
    run_op(3, ang[3], 22'h26DD3, 1'b0, 18, 1);
    req_valid[1] = 1'b1;
    hold_exp = {1'b1, 1'b1, 1'b0, 2'd3, 22'h26DD3};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_hold", 64'({res_valid, busy, res_err, res_tag, res_cos}), 64'(hold_exp));
      chk("stall_ready_zero", 64'(req_ready), 64'(0));
    end
    res_ready = 1'b1;
    #1;
    chk("hs_cycle_no_grant", 64'(req_ready), 64'(0));
    @(negedge clk);
    #1;
    chk("grant_after_hs", 64'(req_ready), 64'(4'b0010));
    run_op(1, ang[1], 22'h26DD3, 1'b0, 18, 1);

    // Reset in the middle of RUN abandons the operation
    @(negedge clk);
    req_valid[0] = 1'b1;
    #1;
    chk("pre_reset_grant", 64'(req_ready), 64'(4'b0001));
    @(negedge clk);
    req_valid = '0;
    repeat (9) @(negedge clk);
    req_valid = 4'b1000;
    reset_n   = 1'b0;
    #1;
    chk("midrun_reset_outputs",
        64'({req_ready, res_valid, res_cos, res_tag, res_err, busy, eng_reset, eng_angle}), 64'(0));
    @(negedge clk);
    chk("midrun_reset_hold",
        64'({req_ready, res_valid, res_cos, res_tag, res_err, busy, eng_reset, eng_angle}), 64'(0));
    reset_n = 1'b1;
    chk("sb_after_reset", 64'(sb.size()), 64'(0));
    run_op(3, ang[3], 22'h26DD3, 1'b0, 18, 1);

    // Done arriving on the timeout cycle still reports success
    @(negedge clk);
    stub_lat     = 31;
    stub_cos     = 22'h0F0F0;
    req_valid[2] = 1'b1;
    run_op(2, ang[2], 22'h0F0F0, 1'b0, 34, 1);

    @(negedge clk);
    @(negedge clk);
    chk("idle_after_all", 64'({res_valid, busy}), 64'(0));
    chk("sb_drained", 64'(sb.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
